// File: rtl/controller_pkg.sv
// Shared constants and read-handshake state encodings for the command
// interpreter front end.
package controller_pkg;

  localparam int BYTES_PER_WORD          = 4;
  localparam int DEF_BYTE_TIMEOUT_CYCLES = 360;

  typedef enum logic [1:0] {
    RD_IDLE    = 2'd0,
    RD_PENDING = 2'd1,
    RD_RESPOND = 2'd2
  } rd_state_e;

endpackage

// File: rtl/word_fifo.sv
// Synchronous word FIFO with occupancy count; pushes become visible to the
// read side one edge later (no write-to-read bypass).
module word_fifo #(
  parameter int WIDTH = 32,
  parameter int DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     push,
  input  logic                     pop,
  input  logic [WIDTH-1:0]         wdata,
  output logic [WIDTH-1:0]         rdata,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [PW-1:0]    wr_ptr_q, wr_ptr_d;
  logic [PW-1:0]    rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]    count_q, count_d;
  logic             push_ok, pop_ok;

  assign empty   = (count_q == CW'(0));
  assign full    = (count_q == CW'(DEPTH));
  assign count   = count_q;
  assign rdata   = mem_q[rd_ptr_q];
  assign pop_ok  = pop && !empty;
  // A pop frees the slot the push lands in, so full+pop still accepts the push.
  assign push_ok = push && (!full || pop_ok);

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (push_ok) wr_ptr_d = wr_ptr_q + PW'(1);
    if (pop_ok)  rd_ptr_d = rd_ptr_q + PW'(1);
    case ({push_ok, pop_ok})
      2'b10:   count_d = count_q + CW'(1);
      2'b01:   count_d = count_q - CW'(1);
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  always_ff @(posedge clk) begin
    if (push_ok) mem_q[wr_ptr_q] <= wdata;
  end

endmodule

// File: rtl/uart_word_receiver.sv
// Packs UART RX bytes big-endian into 32-bit command words, buffers them and
// serves them over the read/response handshake. Optional partial-word
// timeout is built when UART_WORD_TIMEOUT_EN is defined.
module uart_word_receiver
  import controller_pkg::*;
#(
  parameter int FIFO_DEPTH          = 4,
  parameter int BYTE_TIMEOUT_CYCLES = DEF_BYTE_TIMEOUT_CYCLES
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic                          rx_byte_valid,
  input  logic [7:0]                    rx_byte,
  input  logic                          uart_read,
  output logic                          uart_response,
  output logic [31:0]                   uart_read_data,
  output logic                          uart_rx_empty,
  output logic [$clog2(FIFO_DEPTH):0]   word_count,
  output logic                          word_dropped,
  output logic                          frame_timeout
);

  localparam logic [1:0] LAST_IDX = 2'(BYTES_PER_WORD - 1);
  localparam int         PART_W   = (BYTES_PER_WORD - 1) * 8;

  logic [1:0]        idx_q, idx_d;
  logic [PART_W-1:0] part_q, part_d;
  logic              dropped_q, dropped_d;
  logic              byte_last, expire;
  logic              fifo_push, fifo_pop, fifo_full, fifo_empty;
  logic [31:0]       fifo_rdata;
  rd_state_e         rd_state_q;
  logic              response_q;
  logic [31:0]       read_data_q;

  assign byte_last = rx_byte_valid && (idx_q == LAST_IDX);
  assign fifo_pop  = (rd_state_q == RD_RESPOND);
  assign fifo_push = byte_last && (!fifo_full || fifo_pop);

  always_comb begin
    idx_d     = idx_q;
    part_d    = part_q;
    dropped_d = byte_last && fifo_full && !fifo_pop;
    if (rx_byte_valid) begin
      idx_d  = idx_q + 2'd1;
      part_d = {part_q[PART_W-9:0], rx_byte};
    end else if (expire) begin
      idx_d = 2'd0;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      idx_q     <= 2'd0;
      dropped_q <= 1'b0;
    end else begin
      idx_q     <= idx_d;
      dropped_q <= dropped_d;
    end
  end

  always_ff @(posedge clk) begin
    part_q <= part_d;
  end

`ifdef UART_WORD_TIMEOUT_EN
  localparam int TW = $clog2(BYTE_TIMEOUT_CYCLES + 1);

  logic [TW-1:0] idle_q, idle_d;
  logic          timeout_q;

  // A byte on the expiry cycle takes priority over the timeout.
  assign expire = (idx_q != 2'd0) && !rx_byte_valid &&
                  (idle_q == TW'(BYTE_TIMEOUT_CYCLES - 1));

  always_comb begin
    idle_d = idle_q + TW'(1);
    if (rx_byte_valid || (idx_q == 2'd0) || expire) idle_d = '0;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      idle_q    <= '0;
      timeout_q <= 1'b0;
    end else begin
      idle_q    <= idle_d;
      timeout_q <= expire;
    end
  end

  assign frame_timeout = timeout_q;
`else
  assign expire        = 1'b0;
  assign frame_timeout = 1'b0;
`endif

  word_fifo #(
    .WIDTH (32),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk   (clk),
    .rst_n (reset),
    .push  (fifo_push),
    .pop   (fifo_pop),
    .wdata ({part_q, rx_byte}),
    .rdata (fifo_rdata),
    .full  (fifo_full),
    .empty (fifo_empty),
    .count (word_count)
  );

  // Head word is captured on entry to RESPOND; the pop happens at the end of RESPOND.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      rd_state_q  <= RD_IDLE;
      response_q  <= 1'b0;
      read_data_q <= 32'd0;
    end else begin
      response_q <= 1'b0;
      case (rd_state_q)
        RD_IDLE: begin
          if (uart_read) begin
            if (!fifo_empty) begin
              rd_state_q  <= RD_RESPOND;
              response_q  <= 1'b1;
              read_data_q <= fifo_rdata;
            end else begin
              rd_state_q <= RD_PENDING;
            end
          end
        end
        RD_PENDING: begin
          if (!fifo_empty) begin
            rd_state_q  <= RD_RESPOND;
            response_q  <= 1'b1;
            read_data_q <= fifo_rdata;
          end
        end
        RD_RESPOND: rd_state_q <= RD_IDLE;
        default:    rd_state_q <= RD_IDLE;
      endcase
    end
  end

  assign uart_response  = response_q;
  assign uart_read_data = read_data_q;
  assign uart_rx_empty  = fifo_empty;
  assign word_dropped   = dropped_q;

endmodule

// File: tb/tb_uart_word_receiver.sv
// Scoreboard bench for uart_word_receiver: accepted words are queued as they
// are sent and checked in order as responses appear.
module tb_uart_word_receiver;

  localparam int FIFO_DEPTH = 4;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        rx_byte_valid = 1'b0;
  logic [7:0]  rx_byte = 8'h00;
  logic        uart_read = 1'b0;
  logic        uart_response;
  logic [31:0] uart_read_data;
  logic        uart_rx_empty;
  logic [2:0]  word_count;
  logic        word_dropped;
  logic        frame_timeout;

  int n_vec  = 0;
  int n_err  = 0;
  int n_resp = 0;
  int n_drop = 0;
  int n_tmo  = 0;
  int n_acc  = 0;
  logic [31:0] exp_q[$];

  always #5 clk = ~clk;

  uart_word_receiver #(.FIFO_DEPTH(FIFO_DEPTH)) dut (
    .clk            (clk),
    .reset          (reset),
    .rx_byte_valid  (rx_byte_valid),
    .rx_byte        (rx_byte),
    .uart_read      (uart_read),
    .uart_response  (uart_response),
    .uart_read_data (uart_read_data),
    .uart_rx_empty  (uart_rx_empty),
    .word_count     (word_count),
    .word_dropped   (word_dropped),
    .frame_timeout  (frame_timeout)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  always @(negedge clk) begin
    if (uart_response) begin
      n_resp++;
      if (exp_q.size() == 0) chk("resp_extra", exp_q.size(), 1);
      else                   chk("resp_data", uart_read_data, exp_q.pop_front());
    end
    if (word_dropped)  n_drop++;
    if (frame_timeout) n_tmo++;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: got running expected finished");
    $fatal(1, "watchdog expired");
  end

  task automatic send_byte(input logic [7:0] b);
    @(negedge clk);
    rx_byte_valid = 1'b1;
    rx_byte       = b;
    @(negedge clk);
    rx_byte_valid = 1'b0;
  endtask

  task automatic send_word(input logic [31:0] w, input bit accept);
    send_byte(w[31:24]);
    send_byte(w[23:16]);
    send_byte(w[15:8]);
    @(negedge clk);
    rx_byte_valid = 1'b1;
    rx_byte       = w[7:0];
    if (accept) begin
      exp_q.push_back(w);
      n_acc++;
    end
    @(negedge clk);
    rx_byte_valid = 1'b0;
  endtask

  task automatic do_read();
    @(negedge clk);
    uart_read = 1'b1;
    @(negedge clk);
    uart_read = 1'b0;
  endtask

  task automatic wait_resp();
    for (int i = 0; i < 60 && exp_q.size() != 0; i++) @(negedge clk);
    @(negedge clk);
    chk("resp_drain", exp_q.size(), 0);
  endtask

  initial begin
    int d0, r0, t0;

    // Reset values
    repeat (3) @(negedge clk);
    chk("rst_response", uart_response, 0);
    chk("rst_data", uart_read_data, 0);
    chk("rst_empty", uart_rx_empty, 1);
    chk("rst_count", word_count, 0);
    chk("rst_dropped", word_dropped, 0);
    chk("rst_timeout", frame_timeout, 0);
    reset = 1'b1;

    // 1: single word, read latency
    send_word(32'hDEADBEEF, 1);
    chk("t1_count", word_count, 1);
    chk("t1_empty", uart_rx_empty, 0);
    do_read();
    chk("t1_latency", uart_response, 1);
    @(negedge clk);
    chk("t1_empty_after", uart_rx_empty, 1);
    chk("t1_resp_once", uart_response, 0);

    // 2: read while empty, then word arrives
    do_read();
    r0 = n_resp;
    send_word(32'h01020304, 1);
    chk("t2_not_yet", uart_response, 0);
    @(negedge clk);
    chk("t2_resp", uart_response, 1);
    repeat (3) @(negedge clk);
    chk("t2_one_resp", n_resp - r0, 1);

    // 3: overflow drops the fifth word
    d0 = n_drop;
    for (int i = 1; i <= 5; i++) send_word(32'h11111111 * i, i <= FIFO_DEPTH);
    chk("t3_drop_pulse", word_dropped, 1);
    chk("t3_count_full", word_count, 4);
    @(negedge clk);
    chk("t3_drop_once", n_drop - d0, 1);
    for (int i = 0; i < FIFO_DEPTH; i++) do_read();
    wait_resp();
    chk("t3_count_empty", word_count, 0);

    // 4: fourth byte coincides with RESPOND pop on a full FIFO
    for (int i = 0; i < FIFO_DEPTH; i++) send_word(32'hA0A00000 + i, 1);
    chk("t4_count_full", word_count, 4);
    send_byte(8'hC1);
    send_byte(8'hC2);
    send_byte(8'hC3);
    @(negedge clk);
    uart_read = 1'b1;
    @(negedge clk);
    uart_read     = 1'b0;
    rx_byte_valid = 1'b1;
    rx_byte       = 8'hC4;
    exp_q.push_back(32'hC1C2C3C4);
    n_acc++;
    chk("t4_respond_cycle", uart_response, 1);
    @(negedge clk);
    rx_byte_valid = 1'b0;
    chk("t4_no_drop", word_dropped, 0);
    chk("t4_count_kept", word_count, 4);
    for (int i = 0; i < FIFO_DEPTH; i++) do_read();
    wait_resp();

    // 5: partial-word timeout behaviour
    t0 = n_tmo;
    send_byte(8'hAA);
    send_byte(8'hBB);
`ifdef UART_WORD_TIMEOUT_EN
    repeat (359) @(negedge clk);
    send_word(32'h11223344, 1);
    @(negedge clk);
    chk("t5_timeout_once", n_tmo - t0, 1);
    do_read();
    wait_resp();
    t0 = n_tmo;
    send_byte(8'hAA);
    send_byte(8'hBB);
    repeat (358) @(negedge clk);
    send_byte(8'hCC);
    send_byte(8'hDD);
    exp_q.push_back(32'hAABBCCDD);
    n_acc++;
    @(negedge clk);
    chk("t5_expiry_byte_wins", n_tmo - t0, 0);
`else
    repeat (400) @(negedge clk);
    send_byte(8'hCC);
    send_byte(8'hDD);
    exp_q.push_back(32'hAABBCCDD);
    n_acc++;
    @(negedge clk);
    chk("t5_no_timeout", n_tmo - t0, 0);
`endif
    chk("t5_count", word_count, 1);
    do_read();
    wait_resp();

    // 6: reset mid-word with a pending read
    send_byte(8'h12);
    send_byte(8'h34);
    do_read();
    @(negedge clk);
    reset = 1'b0;
    #1;
    chk("t6_rst_response", uart_response, 0);
    chk("t6_rst_data", uart_read_data, 0);
    chk("t6_rst_empty", uart_rx_empty, 1);
    chk("t6_rst_count", word_count, 0);
    @(negedge clk);
    reset = 1'b1;
    send_word(32'h55667788, 1);
    chk("t6_no_stale_pend_a", uart_response, 0);
    @(negedge clk);
    chk("t6_no_stale_pend_b", uart_response, 0);
    do_read();
    wait_resp();

    chk("resp_total", n_resp, n_acc);
    chk("drop_total", n_drop, 1);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
